// File: rtl/decompt_pkg.sv
// Shared types and pin-map constants for the 8-bit loadable down-counter tile.
package decompt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int START_BIT  = 0;
  localparam int PAUSE_BIT  = 1;
  localparam int RELOAD_BIT = 2;
  localparam int PSEL_LSB   = 3;
  localparam int BUSY_BIT   = 6;
  localparam int DONE_BIT   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hC0;

  function automatic logic [7:0] pack_uio_out(input logic busy, input logic done);
    logic [7:0] v;
    v = 8'h00;
    v[BUSY_BIT] = busy;
    v[DONE_BIT] = done;
    return v;
  endfunction

endpackage

// File: rtl/tt_um_decompt_8bits_if.sv
// Tiny Tapeout pin frame bundle: dedicated inputs/outputs plus the bidirectional uio group.
interface tt_um_decompt_8bits_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/decompt_prescaler.sv
// Programmable prescaler: raises tick once every 2^psel clocks while run is high.
module decompt_prescaler #(
  parameter int PSW = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] psel,
  input  logic       run,
  input  logic       clear,
  output logic       tick
);

  logic [PSW-1:0] cnt;
  logic [PSW-1:0] thr;

  // >= rather than == so lowering psel mid-period never strands cnt above the threshold
  assign thr  = ~({PSW{1'b1}} << psel);
  assign tick = run && (cnt >= thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ena) begin
      if (clear)
        cnt <= '0;
      else if (run)
        cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_decompt_8bits.sv
// Loadable down-counter/timer on the Tiny Tapeout frame with pause, auto-reload and done pulse.
//   state | meaning
//   IDLE  | after reset, nothing loaded
//   RUN   | counting down at the prescaled rate
//   PAUSE | count and prescaler frozen until pause drops
//   DONE  | reached zero, waits for the next start edge
module tt_um_decompt_8bits
  import decompt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PSW   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  tt_um_decompt_8bits_if.slave  bus
);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             start_q;
  logic             busy;
  logic             done;
  logic             tick;

  logic       start_in;
  logic       pause_in;
  logic       reload_en;
  logic [2:0] psel;
  logic       start_pulse;
  logic       unused_uio;

  assign start_in    = bus.uio_in[START_BIT];
  assign pause_in    = bus.uio_in[PAUSE_BIT];
  assign reload_en   = bus.uio_in[RELOAD_BIT];
  assign psel        = bus.uio_in[PSEL_LSB +: 3];
  assign start_pulse = start_in & ~start_q;
  assign unused_uio  = ^bus.uio_in[7:6];

  decompt_prescaler #(.PSW(PSW)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .psel  (psel),
    .run   ((state == RUN) && !pause_in),
    .clear (start_pulse),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      start_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (ena) begin
      start_q <= start_in;
      done    <= 1'b0;
      if (start_pulse) begin
        count  <= bus.ui_in;
        reload <= bus.ui_in;
        if (bus.ui_in != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (pause_in) begin
              state <= PAUSE;
            end else if (tick) begin
              if (count > WIDTH'(1)) begin
                count <= count - 1'b1;
              end else if (reload_en) begin
                count <= reload;
                done  <= 1'b1;
              end else begin
                count <= '0;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (!pause_in)
              state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.uo_out  = count;
  assign bus.uio_out = pack_uio_out(busy, done);
  assign bus.uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_decompt_8bits.sv
// Self-checking bench for the down-counter tile: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_tt_um_decompt_8bits;

  logic clk;
  logic rst;
  logic ena;

  tt_um_decompt_8bits_if bus ();

  tt_um_decompt_8bits dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: what the tile must show after the next rising edge
  int m_count   = 0;
  int m_reload  = 0;
  bit m_active  = 0;
  bit m_paused  = 0;
  bit m_done    = 0;
  bit m_prev_st = 0;
  int m_elapsed = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  task automatic model_step(input logic [7:0] ui, input logic [7:0] uio, input bit e, input bit r);
    bit st, pz, ar;
    int period;
    if (r) begin
      m_count = 0; m_reload = 0; m_active = 0; m_paused = 0;
      m_done = 0; m_prev_st = 0; m_elapsed = 0;
      return;
    end
    if (!e) return;
    st = uio[0];
    pz = uio[1];
    ar = uio[2];
    period = 1 << int'(uio[5:3]);
    m_done = 0;
    if (st && !m_prev_st) begin
      m_count = ui; m_reload = ui; m_elapsed = 0; m_paused = 0;
      m_active = (ui != 0);
      m_done = (ui == 0);
    end else if (m_active && !m_paused) begin
      if (pz) begin
        m_paused = 1;
      end else if (m_elapsed + 1 >= period) begin
        m_elapsed = 0;
        if (m_count > 1) begin
          m_count = m_count - 1;
        end else begin
          m_done = 1;
          if (ar) m_count = m_reload;
          else begin
            m_count = 0;
            m_active = 0;
          end
        end
      end else begin
        m_elapsed++;
      end
    end else if (m_active && m_paused && !pz) begin
      m_paused = 0;
    end
    m_prev_st = st;
  endtask

  // Drive one cycle of inputs; returns at the following falling edge with outputs settled
  task automatic cyc(input logic [7:0] ui, input logic [7:0] uio, input bit e, input bit r);
    #1;
    bus.ui_in  = ui;
    bus.uio_in = uio;
    ena = e;
    rst = r;
    model_step(ui, uio, e, r);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model uo_out", int'(bus.uo_out), m_count);
      chk("model uio_out", int'(bus.uio_out), (int'(m_done) << 7) | (int'(m_active) << 6));
      chk("model uio_oe", int'(bus.uio_oe), 8'hC0);
    end
  end

  initial begin
    int exp_seq[4];
    int ar_seq[6];
    int done_at;

    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    ena = 1'b1;
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset and idle
    cyc(8'd0, 8'h00, 1, 1);
    cyc(8'd0, 8'h00, 1, 1);
    for (int i = 0; i < 5; i++) cyc(8'd0, 8'h00, 1, 0);
    chk("idle uo_out", int'(bus.uo_out), 0);
    chk("idle uio_out", int'(bus.uio_out), 0);
    chk("idle uio_oe", int'(bus.uio_oe), 8'hC0);

    // Load 5, divide-by-1
    cyc(8'd5, 8'h01, 1, 0);
    chk("load5 uo_out", int'(bus.uo_out), 5);
    chk("load5 busy", int'(bus.uio_out), 8'h40);
    exp_seq = '{4, 3, 2, 1};
    for (int i = 0; i < 4; i++) begin
      cyc(8'd0, 8'h00, 1, 0);
      chk("count5 uo_out", int'(bus.uo_out), exp_seq[i]);
      chk("count5 uio_out", int'(bus.uio_out), 8'h40);
    end
    cyc(8'd0, 8'h00, 1, 0);
    chk("term5 uo_out", int'(bus.uo_out), 0);
    chk("term5 done", int'(bus.uio_out), 8'h80);
    cyc(8'd0, 8'h00, 1, 0);
    chk("after5 uio_out", int'(bus.uio_out), 0);

    // Load 3, divide-by-4: zero and done 12 clocks after load
    cyc(8'd3, 8'h11, 1, 0);
    chk("load3 uo_out", int'(bus.uo_out), 3);
    done_at = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(8'd0, 8'h10, 1, 0);
      if (i == 4) chk("div4 second value", int'(bus.uo_out), 2);
      if (bus.uio_out[7]) begin
        done_at = i;
        break;
      end
    end
    chk("div4 done latency", done_at, 12);
    chk("div4 terminal", int'(bus.uo_out), 0);

    // Auto-reload with 2
    cyc(8'd2, 8'h05, 1, 0);
    chk("ar load", int'(bus.uo_out), 2);
    ar_seq = '{1, 2, 1, 2, 1, 2};
    for (int i = 0; i < 6; i++) begin
      cyc(8'd0, 8'h04, 1, 0);
      chk("ar uo_out", int'(bus.uo_out), ar_seq[i]);
      chk("ar uio_out", int'(bus.uio_out), (ar_seq[i] == 2) ? 8'hC0 : 8'h40);
    end

    // Start with zero load
    cyc(8'd0, 8'h01, 1, 0);
    chk("zero load uio_out", int'(bus.uio_out), 8'h80);
    cyc(8'd0, 8'h00, 1, 0);
    chk("zero load after", int'(bus.uio_out), 0);

    // Pause mid-count, then restart while paused
    cyc(8'd10, 8'h01, 1, 0);
    for (int i = 0; i < 3; i++) cyc(8'd0, 8'h00, 1, 0);
    chk("pre-pause", int'(bus.uo_out), 7);
    for (int i = 0; i < 4; i++) begin
      cyc(8'd0, 8'h02, 1, 0);
      chk("paused uo_out", int'(bus.uo_out), 7);
    end
    chk("paused busy", int'(bus.uio_out), 8'h40);
    cyc(8'd0, 8'h00, 1, 0);
    chk("resume first", int'(bus.uo_out), 7);
    cyc(8'd0, 8'h00, 1, 0);
    chk("resume decrement", int'(bus.uo_out), 6);
    cyc(8'd0, 8'h02, 1, 0);
    cyc(8'd20, 8'h03, 1, 0);
    chk("restart paused", int'(bus.uo_out), 20);
    chk("restart busy", int'(bus.uio_out), 8'h40);
    cyc(8'd0, 8'h00, 1, 0);

    // Start held high for 10 clocks with load value changing: single load
    cyc(8'd9, 8'h01, 1, 0);
    for (int i = 0; i < 9; i++) cyc(8'd50, 8'h01, 1, 0);
    chk("held start uo_out", int'(bus.uo_out), 0);
    chk("held start done", int'(bus.uio_out), 8'h80);
    cyc(8'd0, 8'h00, 1, 0);

    // Reset mid-run at count 4
    cyc(8'd8, 8'h01, 1, 0);
    for (int i = 0; i < 4; i++) cyc(8'd0, 8'h00, 1, 0);
    chk("pre-reset", int'(bus.uo_out), 4);
    cyc(8'd0, 8'h00, 1, 1);
    chk("reset uo_out", int'(bus.uo_out), 0);
    chk("reset uio_out", int'(bus.uio_out), 0);

    // ena low freezes
    cyc(8'd8, 8'h01, 1, 0);
    cyc(8'd0, 8'h00, 1, 0);
    cyc(8'd0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(8'd0, 8'h00, 0, 0);
      chk("ena low hold", int'(bus.uo_out), 6);
    end
    cyc(8'd0, 8'h00, 1, 0);
    chk("ena resume", int'(bus.uo_out), 5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ui, uio;
      bit e, r;
      ui = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      uio = 8'($urandom) & 8'hC4;
      uio[0] = ($urandom_range(0, 9) == 0);
      uio[1] = ($urandom_range(0, 7) == 0);
      uio[5:3] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      e = ($urandom_range(0, 19) != 0);
      r = ($urandom_range(0, 199) == 0);
      cyc(ui, uio, e, r);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_decompt_8bits.md
Name: tt_um_decompt_8bits

Overview:
- Loadable 8-bit down-counter/timer: the count-down counterpart of the team's 8-bit up-counter tile, built on the same Tiny Tapeout pin frame.
- A start edge loads a value from ui_in. The block decrements it at a programmable prescaled rate and flags terminal count on a uio pin.
- Optional auto-reload turns it into a periodic event generator for the counter tile and external logic.

Parameters:
- WIDTH, 8, counter/load width (uo_out and ui_in mapping assume 8)
- PSW, 7, prescaler counter width; supports divide-by up to 2^PSW

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- ena  input  1  tile enable; low freezes all registers
- ui_in  input  8  load value captured on start
- uio_in  input  8  [0] start, [1] pause, [2] auto_reload, [5:3] psel (tick every 2^psel clocks), [7:6] unused
- uo_out  output  8  current count
- uio_out  output  8  [6] busy, [7] done (1-cycle pulse), [5:0] = 0
- uio_oe  output  8  constant 8'b1100_0000

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- rst=1 at a clk edge clears count=0, reload=0, prescaler=0, start_q=0, state=IDLE, busy=0, done=0. rst overrides ena.
- ena=0: every register holds, including the edge detector and done. A done pulse in flight is stretched until ena returns; accepted.
- Start detection:
  - start_q registers uio_in[0].
  - start_pulse = uio_in[0] & ~start_q.
  - A level held high gives exactly one start.
- States are IDLE, RUN, PAUSE, DONE. start_pulse is accepted in every state and has top priority after rst:
  - count <= ui_in, reload <= ui_in, prescaler <= 0.
  - If ui_in != 0, next state is RUN.
  - If ui_in == 0, next state is DONE and done=1 on the next cycle.
  - New count appears on uo_out one cycle after the edge is sampled.
- Tick: tick = (prescaler >= 2^psel - 1), evaluated in RUN only.
  - On tick, prescaler <= 0; otherwise prescaler increments.
  - psel=0 gives a tick every clock.
  - psel changed mid-run takes effect immediately. The >= compare prevents a wrap stall.
- RUN:
  - pause=1 (and no start) -> PAUSE. count and prescaler hold.
  - On tick with count > 1: count <= count - 1.
  - On tick with count == 1 and auto_reload=0: count <= 0, state <= DONE, done=1 for one cycle.
  - On tick with count == 1 and auto_reload=1: count <= reload, stay in RUN, done=1 for one cycle.
- PAUSE: pause=0 -> RUN, resuming the prescaler where it stopped. start_pulse overrides.
- DONE: count holds 0 and done=0 after its single pulse. Leaves only via start_pulse.
- busy = 1 in RUN and PAUSE; 0 in IDLE and DONE. busy is registered, aligned with the state register.
- done is registered and asserted in the same cycle uo_out first shows the terminal value (0, or reload when auto-reloading).
- Simultaneous events:
  - start with tick: start wins, no decrement.
  - start with pause=1: load happens, RUN is entered, then PAUSE next cycle if pause is still high.
  - auto_reload toggled mid-run is sampled only at the count==1 tick.
- No underflow: count never wraps from 0 to 255.
- All outputs are registers, or constants for uio_oe and uio_out[5:0].

Decomposition:
- Shared package (decompt_pkg) holds:
  - state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3)
  - uio bit-index constants (START_BIT=0, PAUSE_BIT=1, RELOAD_BIT=2, PSEL_LSB=3, BUSY_BIT=6, DONE_BIT=7)
  - UIO_OE_MASK=8'hC0
- One sub-module, decompt_prescaler: psel, run/clear inputs, tick output.
- The top holds the FSM, count/reload registers and the edge detector.

Test Plan:
- Reset, then idle for 5 clocks -> uo_out=0, uio_out=0, uio_oe=8'hC0.
- ui_in=5, psel=0, start pulse -> uo_out counts 5,4,3,2,1,0 on successive clocks. busy high from the load cycle through the 1 cycle. done high exactly in the cycle uo_out=0, then DONE state holds 0.
- ui_in=3, psel=2 (divide-by-4) -> each count value is held 4 clocks; done appears 12 clocks after load.
- ui_in=2, auto_reload=1, psel=0 -> sequence 2,1,2,1,... with done on each reload cycle. busy stays 1.
- Pause mid-count: load 10, pause after 3 decrements -> uo_out frozen at 7 while pause=1, resumes 6... after release. Second start with ui_in=20 while paused -> count=20, busy=1.
- Edge cases:
  - start with ui_in=0 -> done pulse next cycle, busy never set.
  - start held high for 10 clocks -> a single load.
  - rst asserted mid-RUN at count=4 -> all outputs 0 next cycle.
  - ena=0 for 5 clocks mid-RUN -> count unchanged.
